// File: rtl/alu_issue_stage.sv
// Operand/issue stage for the 32-bit ALU: register file, single-instruction
// IDLE->EXEC->WB sequencing, result hand-off and write-back.
module alu_issue_stage #(
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_op,
  input  logic [AW-1:0] in_rd,
  input  logic [AW-1:0] in_rs1,
  input  logic [AW-1:0] in_rs2,
  input  logic [31:0]   in_imm,
  input  logic          in_use_imm,
  output logic [31:0]   alu_a,
  output logic [31:0]   alu_b,
  output logic [3:0]    alu_cnt,
  input  logic [31:0]   alu_result,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_rd,
  output logic [31:0]   out_data,
  input  logic [AW-1:0] dbg_addr,
  output logic [31:0]   dbg_data
);

  localparam int NREGS = 2**AW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t        state;
  logic [31:0]   regs [NREGS];
  logic [AW-1:0] rd_q;

  // in_ready/out_valid are flops that move in lockstep with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_cnt   <= '0;
      rd_q      <= '0;
      out_rd    <= '0;
      out_data  <= '0;
      regs      <= '{default: '0};
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            alu_a     <= regs[in_rs1];
            alu_b     <= in_use_imm ? in_imm : regs[in_rs2];
            alu_cnt   <= in_op;
            rd_q      <= in_rd;
            state     <= EXEC;
            in_ready  <= 1'b0;
          end
        end
        EXEC: begin
          out_data  <= alu_result;
          out_rd    <= rd_q;
          state     <= WB;
          out_valid <= 1'b1;
        end
        WB: begin
          if (out_ready) begin
            // r0 stays hardwired to zero; the result was still presented.
            if (out_rd != '0) regs[out_rd] <= out_data;
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign dbg_data = regs[dbg_addr];

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: behavioural ALU, register-file model,
// directed scenarios and randomized instruction streams.
module tb_alu_issue_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [2:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        in_use_imm;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_cnt;
  logic [31:0] alu_result;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_rd;
  logic [31:0] out_data;
  logic [2:0]  dbg_addr;
  logic [31:0] dbg_data;

  int checks = 0;
  int errors = 0;
  logic [31:0] mdl [8];

  alu_issue_stage #(.AW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_use_imm(in_use_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cnt(alu_cnt), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd), .out_data(out_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [5:0] sh;
    sh = {1'b0, b[4:0]};
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a << sh;
      4'd5:    return a >> sh;
      4'd6:    return $unsigned($signed(a) >>> sh);
      4'd7:    return (a << sh) | (a >> (6'd32 - sh));
      4'd8:    return a ^ b;
      4'd9:    return (a >> sh) | (a << (6'd32 - sh));
      4'd10:   return {31'b0, $signed(a) < $signed(b)};
      4'd11:   return {31'b0, a < b};
      4'd12:   return ~a;
      default: return 32'h0;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_cnt, alu_a, alu_b);

  // Full transaction: issue, check operands, check result, stall, hand off, check write-back.
  task automatic do_instr(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                          input logic [2:0] rs2, input logic [31:0] imm, input logic use_imm,
                          input int stall);
    logic [31:0] ea, eb, er;
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ready_timeout in_ready=%b want 1", in_ready); end
    ea = mdl[rs1];
    eb = use_imm ? imm : mdl[rs2];
    er = alu_fn(op, ea, eb);
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_use_imm = use_imm;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (alu_a !== ea) begin errors++; $display("FAIL alu_a got=%h want=%h", alu_a, ea); end
    checks++; if (alu_b !== eb) begin errors++; $display("FAIL alu_b got=%h want=%h", alu_b, eb); end
    checks++; if (alu_cnt !== op) begin errors++; $display("FAIL alu_cnt got=%h want=%h", alu_cnt, op); end
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL exec_flags in_ready=%b out_valid=%b want 0 0", in_ready, out_valid); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL wb_valid got=%b want 1", out_valid); end
    checks++; if (out_data !== er) begin errors++; $display("FAIL out_data op=%h got=%h want=%h", op, out_data, er); end
    checks++; if (out_rd !== rd) begin errors++; $display("FAIL out_rd got=%0d want=%0d", out_rd, rd); end
    dbg_addr = rd;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== er || out_rd !== rd || dbg_data !== mdl[rd]) begin
        errors++;
        $display("FAIL stall_hold v=%b r=%b data=%h rd=%0d dbg=%h want 1 0 %h %0d %h",
                 out_valid, in_ready, out_data, out_rd, dbg_data, er, rd, mdl[rd]);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    if (rd != 3'd0) mdl[rd] = er;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL after_wb v=%b r=%b want 0 1", out_valid, in_ready); end
    checks++; if (dbg_data !== mdl[rd]) begin errors++; $display("FAIL writeback r%0d got=%h want=%h", rd, dbg_data, mdl[rd]); end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) mdl[i] = '0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL reset_flags r=%b v=%b want 1 0", in_ready, out_valid); end
    checks++; if (alu_a !== 32'h0 || alu_b !== 32'h0 || alu_cnt !== 4'h0) begin errors++; $display("FAIL reset_alu a=%h b=%h c=%h want 0", alu_a, alu_b, alu_cnt); end
    checks++; if (out_data !== 32'h0 || out_rd !== 3'h0) begin errors++; $display("FAIL reset_out data=%h rd=%0d want 0", out_data, out_rd); end
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i); #1;
      checks++; if (dbg_data !== 32'h0) begin errors++; $display("FAIL reset_reg r%0d got=%h want 0", i, dbg_data); end
    end
  endtask

  task automatic test_immediate;
    do_instr(4'b0000, 3'd1, 3'd0, 3'd0, 32'd5, 1'b1, 0);
    dbg_addr = 3'd1; #1;
    checks++; if (dbg_data !== 32'd5) begin errors++; $display("FAIL imm_r1 got=%h want=5", dbg_data); end
  endtask

  task automatic test_dependent_sub;
    do_instr(4'b0000, 3'd2, 3'd0, 3'd0, 32'd8, 1'b1, 0);
    do_instr(4'b0001, 3'd3, 3'd1, 3'd2, 32'hDEAD_BEEF, 1'b0, 0);
    dbg_addr = 3'd3; #1;
    checks++; if (dbg_data !== 32'hFFFF_FFFD) begin errors++; $display("FAIL sub_r3 got=%h want=fffffffd", dbg_data); end
  endtask

  task automatic test_backpressure;
    do_instr(4'b0011, 3'd5, 3'd3, 3'd0, 32'h0000_0F00, 1'b1, 4);
    do_instr(4'b0111, 3'd6, 3'd5, 3'd0, 32'd36, 1'b1, 2);
  endtask

  task automatic test_r0_and_reserved;
    do_instr(4'b0000, 3'd0, 3'd0, 3'd0, 32'd7, 1'b1, 1);
    dbg_addr = 3'd0; #1;
    checks++; if (dbg_data !== 32'h0) begin errors++; $display("FAIL r0_write got=%h want 0", dbg_data); end
    do_instr(4'b0000, 3'd4, 3'd0, 3'd0, 32'h1234_5678, 1'b1, 0);
    do_instr(4'b1111, 3'd4, 3'd3, 3'd2, 32'h0, 1'b0, 0);
    dbg_addr = 3'd4; #1;
    checks++; if (dbg_data !== 32'h0) begin errors++; $display("FAIL op15_r4 got=%h want 0", dbg_data); end
  endtask

  // in_valid held with different fields through EXEC and WB must not disturb the operands.
  task automatic test_in_valid_ignored;
    logic [31:0] ea;
    ea = mdl[3];
    in_op = 4'b0010; in_rd = 3'd7; in_rs1 = 3'd3; in_rs2 = 3'd3; in_imm = 32'hFFFF_0000; in_use_imm = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_rs1 = 3'd2; in_imm = 32'h1111_1111; in_op = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (alu_a !== ea || alu_b !== 32'hFFFF_0000 || alu_cnt !== 4'b0010) begin
        errors++;
        $display("FAIL busy_capture a=%h b=%h c=%h want %h ffff0000 2", alu_a, alu_b, alu_cnt, ea);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    mdl[7] = ea & 32'hFFFF_0000;
    dbg_addr = 3'd7; #1;
    checks++; if (dbg_data !== mdl[7] || in_ready !== 1'b1) begin errors++; $display("FAIL busy_wb r7=%h r=%b want %h 1", dbg_data, in_ready, mdl[7]); end
  endtask

  task automatic test_reset_mid_op;
    do_instr(4'b0000, 3'd2, 3'd0, 3'd0, 32'd9, 1'b1, 0);
    in_op = 4'b1000; in_rd = 3'd2; in_rs1 = 3'd2; in_rs2 = 3'd0; in_imm = 32'h3; in_use_imm = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0; #1;
    for (int i = 0; i < 8; i++) mdl[i] = '0;
    dbg_addr = 3'd2; #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL midop_flags r=%b v=%b want 1 0", in_ready, out_valid); end
    checks++; if (dbg_data !== 32'h0 || alu_a !== 32'h0 || alu_b !== 32'h0) begin errors++; $display("FAIL midop_clear r2=%h a=%h b=%h want 0", dbg_data, alu_a, alu_b); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || dbg_data !== 32'h0) begin errors++; $display("FAIL midop_discard v=%b r2=%h want 0 0", out_valid, dbg_data); end
  endtask

  task automatic test_random;
    for (int k = 0; k < 60; k++) begin
      do_instr(4'($urandom_range(15)), 3'($urandom_range(7)), 3'($urandom_range(7)), 3'($urandom_range(7)),
               ($urandom_range(3) == 0) ? 32'($urandom_range(40)) : $urandom,
               1'($urandom_range(1)), int'($urandom_range(3)));
    end
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i); #1;
      checks++; if (dbg_data !== mdl[i]) begin errors++; $display("FAIL rand_regfile r%0d got=%h want=%h", i, dbg_data, mdl[i]); end
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_imm = '0; in_use_imm = 1'b0; out_ready = 1'b0; dbg_addr = '0;
    for (int i = 0; i < 8; i++) mdl[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    test_immediate;
    test_dependent_sub;
    test_backpressure;
    test_r0_and_reserved;
    test_in_valid_ignored;
    test_reset_mid_op;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
